// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding,
// default sizing constants and the counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH          = 32;
  localparam int DEFAULT_BITS_PER_CYCLE = 1;

  // Counter width to hold 0..n-1; never narrower than one bit so a
  // single-step configuration still elaborates a legal vector.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
import serial_sub_pkg::*;

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: out = in1 - in2, BITS_PER_CYCLE bits per clock,
// LSB first, using a borrow chain of full_subtractor cells.
// Optional feature macro SERIAL_SUB_OVF_EN adds the signed overflow output.
import serial_sub_pkg::*;

module serial_subtractor #(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int BITS_PER_CYCLE = DEFAULT_BITS_PER_CYCLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject configurations where the step size does not tile the operand.
  if ((BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH exactly");
  end

  state_t             state_r;
  state_t             state_n_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_next_s;
  logic               borrow_r;
  logic               accept_s;
  logic               run_step_s;
  logic               finish_s;
  logic               busy_n_s;
  logic               done_n_s;

  logic [BITS_PER_CYCLE-1:0] diff_s;
  logic [BITS_PER_CYCLE:0]   borrow_chain_s;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_r;
  logic b_msb_r;
`endif

  // Per-cycle borrow chain over the low slice of both operand registers.
  assign borrow_chain_s[0] = borrow_r;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
    full_subtractor u_fs (
      .a    (a_r[i]),
      .b    (b_r[i]),
      .bin  (borrow_chain_s[i]),
      .d    (diff_s[i]),
      .bout (borrow_chain_s[i+1])
    );
  end

  // New difference bits enter from the MSB side; after N steps the first
  // slice computed has walked down to bit 0.
  assign res_next_s = WIDTH'({diff_s, res_r} >> BITS_PER_CYCLE);

  // Next-state and handshake decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_n_s  = state_r;
    accept_s   = 1'b0;
    run_step_s = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s  = 1'b1;
          state_n_s = RUN;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        run_step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          finish_s  = 1'b1;
          state_n_s = DONE;
        end else begin
          state_n_s = RUN;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
    busy_n_s = (state_n_s == RUN);
    done_n_s = (state_n_s == DONE);
  end

  // State register and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_n_s;
      busy    <= busy_n_s;
      done    <= done_n_s;
    end
  end

  // Operand capture, per-step shifting and result/flag update at the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      res_r      <= {WIDTH{1'b0}};
      borrow_r   <= 1'b0;
      out        <= {WIDTH{1'b0}};
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else if (accept_s) begin
      cnt_r    <= {CNT_W{1'b0}};
      a_r      <= in1;
      b_r      <= in2;
      res_r    <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r  <= in1[WIDTH-1];
      b_msb_r  <= in2[WIDTH-1];
`endif
    end else if (run_step_s) begin
      cnt_r    <= cnt_r + CNT_ONE;
      a_r      <= a_r >> BITS_PER_CYCLE;
      b_r      <= b_r >> BITS_PER_CYCLE;
      res_r    <= res_next_s;
      borrow_r <= borrow_chain_s[BITS_PER_CYCLE];
      if (finish_s) begin
        out        <= res_next_s;
        borrow_out <= borrow_chain_s[BITS_PER_CYCLE];
`ifdef SERIAL_SUB_OVF_EN
        overflow   <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ res_next_s[WIDTH-1]);
`endif
      end else begin
        out        <= out;
        borrow_out <= borrow_out;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, mid-run
// corner sequences and random pairs against an arithmetic reference.
module tb_serial_subtractor;

  localparam int WIDTH   = 32;
  localparam int BPC     = 1;
  localparam int N       = WIDTH / BPC;
  localparam int TIMEOUT = 4 * N + 20;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif

  int tests_run;
  int tests_failed;

  serial_subtractor #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .busy       (busy),
    .done       (done),
    .out        (out),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_borrow;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: modular difference, unsigned compare, and signed range test.
  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic br, output logic ov);
    longint sa;
    longint sb;
    longint sd;
    d  = a - b;
    br = (a < b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sd = sa - sb;
    ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, output int cyc, output int busy_cnt);
    cyc      = start_cnt;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < TIMEOUT) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_ovf(input string name, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    check(name, {63'd0, overflow}, {63'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic eb, input logic ev);
    int cyc;
    int bc;
    logic [31:0] held;
    start_op(a, b);
    wait_done(0, cyc, bc);
    check({name, "_latency"}, 64'(cyc), 64'(N));
    check({name, "_busy_cycles"}, 64'(bc), 64'(N));
    check({name, "_out"}, {32'd0, out}, {32'd0, eo});
    check({name, "_borrow"}, {63'd0, borrow_out}, {63'd0, eb});
    check_ovf({name, "_ovf"}, ev);
    held = out;
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({name, "_out_held"}, {32'd0, out}, {32'd0, held});
  endtask

  initial begin
    int cyc;
    int bc;
    int mid;
    int done_seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rd;
    logic        rbr;
    logic        rov;

    tests_run    = 0;
    tests_failed = 0;
    start = 1'b0;
    in1   = 32'd0;
    in2   = 32'd0;
    rst_n = 1'b0;

    vecs[0] = '{32'd100,        32'd58,         32'd42,         1'b0, 1'b0};
    vecs[1] = '{32'd0,          32'd1,          32'hFFFFFFFF,   1'b1, 1'b0};
    vecs[2] = '{32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 1'b1};
    vecs[3] = '{32'hDEADBEEF,   32'hDEADBEEF,   32'd0,          1'b0, 1'b0};
    vecs[4] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b0, 1'b0};
    vecs[5] = '{32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000,   1'b1, 1'b1};
    vecs[6] = '{32'h12345678,   32'h02345670,   32'h10000008,   1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_out", {32'd0, out}, 64'd0);
    check("reset_borrow", {63'd0, borrow_out}, 64'd0);
    check_ovf("reset_ovf", 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
              vecs[i].exp_out, vecs[i].exp_borrow, vecs[i].exp_ovf);
    end

    // start and operand changes during RUN must be ignored
    mid = (N > 12) ? 10 : N / 2;
    start_op(32'd1000, 32'd1);
    repeat (mid) begin
      @(posedge clk);
      #1;
    end
    in1   = 32'd5;
    in2   = 32'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(mid + 1, cyc, bc);
    check("ignore_latency", 64'(cyc), 64'(N));
    check("ignore_out", {32'd0, out}, 64'd999);
    check("ignore_borrow", {63'd0, borrow_out}, 64'd0);
    @(posedge clk);
    #1;

    // reset in the middle of RUN discards the operation
    start_op(32'd3, 32'd10);
    repeat (mid) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_out", {32'd0, out}, 64'd0);
    check("midrst_borrow", {63'd0, borrow_out}, 64'd0);
    done_seen = 0;
    repeat (N + 5) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

    // back-to-back accept while in DONE
    start_op(32'd50, 32'd20);
    wait_done(0, cyc, bc);
    check("b2b_first_out", {32'd0, out}, 64'd30);
    start = 1'b1;
    in1   = 32'd7;
    in2   = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_done_drop", {63'd0, done}, 64'd0);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    check("b2b_out_held", {32'd0, out}, 64'd30);
    wait_done(0, cyc, bc);
    check("b2b_latency", 64'(cyc), 64'(N));
    check("b2b_out", {32'd0, out}, {32'd0, 32'hFFFFFFFE});
    check("b2b_borrow", {63'd0, borrow_out}, 64'd1);
    @(posedge clk);
    #1;

    // random pairs against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = (i % 6 == 0) ? ra : $urandom;
      if (i % 5 == 1) rb = {1'b1, rb[30:0]};
      ref_sub(ra, rb, rd, rbr, rov);
      run_vec($sformatf("rnd%0d", i), ra, rb, rd, rbr, rov);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
